// File: rtl/xadc_sample_sequencer_if.sv
// Signal bundle between the XADC wizard, the sample sequencer and the FIR filter.
// The master modport is the sequencer; the slave modport is the XADC/filter side.
interface xadc_sample_sequencer_if;
  logic        en;
  logic        err_clr;
  logic        eoc_in;
  logic        drdy_in;
  logic [15:0] do_in;
  logic        den_out;
  logic [6:0]  daddr_out;
  logic [7:0]  sample_out;
  logic        sample_valid;
  logic [15:0] sample_count;
  logic        timeout_err;
  logic        overrun_err;

  modport master (
    input  en, err_clr, eoc_in, drdy_in, do_in,
    output den_out, daddr_out, sample_out, sample_valid, sample_count,
           timeout_err, overrun_err
  );

  modport slave (
    output en, err_clr, eoc_in, drdy_in, do_in,
    input  den_out, daddr_out, sample_out, sample_valid, sample_count,
           timeout_err, overrun_err
  );
endinterface

// File: rtl/xadc_sample_sequencer.sv
// Issues one DRP read per XADC end-of-conversion, captures the upper result byte,
// decimates and optionally converts it to two's complement for the FIR filter.
module xadc_sample_sequencer #(
  parameter logic [6:0]  ADDR       = 7'h16,
  parameter int unsigned TIMEOUT    = 15,
  parameter int unsigned DECIM      = 1,
  parameter bit          SIGNED_OUT = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  xadc_sample_sequencer_if.master       bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0] DEC_LAST = 8'(DECIM - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic [7:0]  dec_cnt_q, dec_cnt_d;
  logic        den_q, den_d;
  logic [7:0]  sample_q, sample_d;
  logic        sample_valid_q, sample_valid_d;
  logic [15:0] sample_count_q, sample_count_d;
  logic        timeout_err_q, timeout_err_d;
  logic        overrun_err_q, overrun_err_d;

  logic [7:0]  cap_byte;
  logic        tmo_ev;
  logic        ovr_ev;
  logic        unused_do_lo;

  assign unused_do_lo = ^bus.do_in[7:0];

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    dec_cnt_d      = dec_cnt_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    sample_count_d = sample_count_q;
    tmo_ev         = 1'b0;
    ovr_ev         = bus.eoc_in && (state_q != IDLE);
    cap_byte       = bus.do_in[15:8] ^ {SIGNED_OUT, 7'b0};

    case (state_q)
      IDLE: begin
        if (bus.eoc_in && bus.en) state_d = REQ;
      end
      REQ: begin
        state_d = WAIT;
        timer_d = '0;
      end
      WAIT: begin
        // drdy is checked before the timer, so a result arriving on the last
        // permitted cycle is still captured.
        if (bus.drdy_in) begin
          state_d = IDLE;
          if (dec_cnt_q == DEC_LAST) begin
            sample_d       = cap_byte;
            sample_valid_d = 1'b1;
            sample_count_d = sample_count_q + 16'd1;
            dec_cnt_d      = '0;
          end else begin
            dec_cnt_d = dec_cnt_q + 8'd1;
          end
        end else if (timer_q == TMO_LAST) begin
          tmo_ev  = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    den_d         = (state_d == REQ);
    timeout_err_d = (timeout_err_q & ~bus.err_clr) | tmo_ev;
    overrun_err_d = (overrun_err_q & ~bus.err_clr) | ovr_ev;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      dec_cnt_q      <= '0;
      den_q          <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      sample_count_q <= '0;
      timeout_err_q  <= 1'b0;
      overrun_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      dec_cnt_q      <= dec_cnt_d;
      den_q          <= den_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      sample_count_q <= sample_count_d;
      timeout_err_q  <= timeout_err_d;
      overrun_err_q  <= overrun_err_d;
    end
  end

  assign bus.den_out      = den_q;
  assign bus.daddr_out    = ADDR;
  assign bus.sample_out   = sample_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.sample_count = sample_count_q;
  assign bus.timeout_err  = timeout_err_q;
  assign bus.overrun_err  = overrun_err_q;

endmodule

// File: doc/xadc_sample_sequencer.md
Name: xadc_sample_sequencer

Overview:
- Sequences XADC DRP reads for the FIR datapath.
- On each XADC end-of-conversion pulse it issues one DRP read of the aux channel.
- It waits for data-ready with a timeout, captures the upper 8 bits of the result, applies optional decimation and sign conversion, then presents a one-cycle-valid sample to the filter.
- Sits between the XADC wizard instance and the filter; replaces the direct eoc→den loop-back.

Parameters:
- ADDR, 7'h16, DRP address read on every conversion (aux channel 6 result register).
- TIMEOUT, 15, max cycles spent in WAIT without drdy before abort (1..255).
- DECIM, 1, emit one sample per DECIM successful reads (1..255; 1 = no decimation).
- SIGNED_OUT, 1, 1 = invert MSB of captured byte (offset-binary → two's complement); 0 = raw byte.

Ports:
- clk  in  1  system clock (100 MHz); also drives XADC dclk_in.
- rst  in  1  synchronous, active-high reset.
- en  in  1  accept new conversions when 1; in-flight read always completes.
- err_clr  in  1  one-cycle pulse, clears sticky error flags.
- eoc_in  in  1  XADC eoc_out, one-cycle pulse per conversion.
- drdy_in  in  1  XADC drdy_out.
- do_in  in  16  XADC do_out; result in [15:4], only [15:8] used.
- den_out  out  1  DRP enable to XADC, one-cycle pulse.
- daddr_out  out  7  DRP address to XADC.
- sample_out  out  8  captured, converted sample to filter sig_in.
- sample_valid  out  1  one-cycle strobe, sample_out updated this cycle.
- sample_count  out  16  number of samples emitted, wraps.
- timeout_err  out  1  sticky: a read timed out.
- overrun_err  out  1  sticky: eoc arrived while a read was in flight.

Behaviour:
- Reset values (clk edge with rst=1):
  - state=IDLE.
  - den_out=0, daddr_out=ADDR, sample_out=8'h00, sample_valid=0.
  - sample_count=0, timeout_err=0, overrun_err=0.
  - Decimation counter=0, wait timer=0.
  - rst wins over every other input, including mid-read. An aborted read produces no sample and no error.
- daddr_out is constant ADDR outside reset. No DRP writes are ever issued.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: eoc_in=1 and en=1 → REQ. eoc_in with en=0 is ignored and is not an overrun. drdy_in is ignored.
  - REQ: lasts exactly one cycle. den_out=1 in this cycle only. → WAIT, timer=0. drdy_in is ignored in REQ.
  - WAIT, drdy_in=1: capture byte=do_in[15:8]. If SIGNED_OUT, byte[7] is inverted. Then → IDLE.
  - WAIT, no drdy_in: timer increments. When timer reaches TIMEOUT-1 without drdy, set timeout_err, → IDLE, no capture, decimation counter unchanged.
- den_out and sample_valid are registered (state-decoded, glitch-free).
- Timing: eoc_in at cycle n → den_out at n+1. If drdy_in at n+2, then sample_out/sample_valid appear at n+3. Minimum eoc→sample_valid latency is 3 cycles.
- Decimation (on each successful capture):
  - If dec_cnt==DECIM-1: sample_out←byte, sample_valid=1 for one cycle, sample_count+1 (0xFFFF wraps to 0x0000), dec_cnt←0.
  - Otherwise: dec_cnt+1; sample_out holds, sample_valid=0.
- sample_out holds its value between strobes.
- Overrun: eoc_in=1 while in REQ or WAIT sets overrun_err. That eoc is dropped (no queued read). This applies even if drdy_in arrives in the same cycle: the capture proceeds and the flag is also set.
- err_clr clears both sticky flags. If err_clr and a new error event occur in the same cycle, the flag ends up set (set wins).
- en falling during REQ/WAIT does not abort the read. The next eoc is ignored while en=0.

Test Plan:
- Reset with rst=1 for 2 cycles → all outputs at reset values, daddr_out=7'h16, den_out never pulses while rst=1.
- Single conversion: eoc at cycle 10, drdy at 12 with do_in=16'hA5C0 → den_out=1 only at cycle 11; sample_valid=1 only at 13; sample_out=8'h25 (SIGNED_OUT=1), sample_count=1. Repeat with SIGNED_OUT=0 → sample_out=8'hA5.
- Timeout: eoc, never drdy, TIMEOUT=15 → timeout_err=1 after 15 cycles in WAIT, no sample_valid. A following normal read succeeds with timeout_err still 1. err_clr pulse → 0.
- Overrun: eoc, then a second eoc 1 cycle after den while in WAIT → overrun_err=1, only one den_out pulse. Also eoc with drdy in the same WAIT cycle → sample captured and overrun_err=1.
- Decimation: DECIM=4, 8 good reads with do_in[15:8]=1..8 → exactly 2 strobes, carrying 8'h84 and 8'h88 (SIGNED_OUT=1), sample_count=2.
- Enable/reset/wrap:
  - en=0 with eoc pulses → no den_out, no overrun.
  - rst asserted while in WAIT → IDLE next cycle, no sample, no flags.
  - Preload 65535 samples (or force sample_count) → next strobe wraps sample_count to 0.
